// File: rtl/window_gen_3x3.sv
// window_gen_3x3: turns a raster pixel stream into 3x3 neighbourhood windows.
// Two line buffers keep the previous two rows. A 3x3 shift register slides along
// the current row. A window is flagged valid only when it lies fully inside the frame.
module window_gen_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9*DATA_W-1:0] out_window,
    output logic [6:0]          out_row,
    output logic [6:0]          out_col,
    output logic                frame_done
);

    localparam int         CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [6:0] LAST_COL = 7'(IMG_W - 1);
    localparam logic [6:0] LAST_ROW = 7'(IMG_H - 1);

    logic [6:0]        row;
    logic [6:0]        col;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] win [3][3];

    logic              accept;
    logic              win_ok;
    logic              last_px;
    logic [CW-1:0]     col_idx;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    // A pending window blocks new pixels. This keeps the window registers frozen
    // while downstream stalls.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign col_idx  = col[CW-1:0];
    assign lb0_rd   = lb0[col_idx];
    assign lb1_rd   = lb1[col_idx];

    // Windows touching the top two rows or left two columns would mix in
    // pixels from another row or frame.
    assign win_ok   = (row >= 7'd2) && (col >= 7'd2);
    assign last_px  = (row == LAST_ROW) && (col == LAST_COL);

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? 7'd0 : row + 7'd1;
            end else begin
                col <= col + 7'd1;
            end
        end
    end

    // Line buffers shift one row down per column; contents are left unreset on purpose.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb0[col_idx] <= lb1_rd;
            lb1[col_idx] <= in_pixel;
        end
    end

    // Slide the 3x3 window left and load the new right-hand column.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= in_pixel;
        end
    end

    // Output handshake, window centre and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_px;
            if (accept) begin
                out_valid <= win_ok;
                if (win_ok) begin
                    out_row <= row - 7'd1;
                    out_col <= col - 7'd1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Flatten the window so that element r*3+c sits at bits [(r*3+c)*DATA_W +: DATA_W].
    always_comb begin
        out_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                out_window[(r*3+c)*DATA_W +: DATA_W] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: scoreboard bench for window_gen_3x3 on a 4x4 frame.
module tb_window_gen_3x3;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_pixel = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [9*DATA_W-1:0] out_window;
    logic [6:0]          out_row;
    logic [6:0]          out_col;
    logic                frame_done;

    typedef struct {
        logic [71:0] win;
        logic [6:0]  row;
        logic [6:0]  col;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  frame [IMG_H][IMG_W];
    int          mr = 0;
    int          mc = 0;
    logic        exp_valid = 1'b0;
    logic        exp_fd = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          win_cnt = 0;
    int          fd_cnt = 0;
    int          stall_seen = 0;
    logic [71:0] first_win = '0;
    logic [71:0] fd_win = '0;

    bit          rdy_random = 1'b0;
    bit          stall_arm = 1'b0;
    int          stall_left = 0;

    localparam logic [71:0] RAMP_FIRST = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] RAMP_LAST  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
    localparam logic [71:0] F2_FIRST   = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104,
                                          8'd102, 8'd101, 8'd100};

    window_gen_3x3 #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_window(out_window),
        .out_row   (out_row),
        .out_col   (out_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: normally high. It can be random, or it can stall for five
    // cycles starting on the first window after arming.
    always @(posedge clk) begin
        #1;
        if (stall_arm && out_valid) begin
            stall_arm  = 1'b0;
            stall_left = 4;
            out_ready  = 1'b0;
        end else if (stall_left > 0) begin
            stall_left--;
            out_ready = 1'b0;
        end else if (rdy_random) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor and reference raster model. Values sampled at the negedge hold for
    // the next rising edge.
    always @(negedge clk) begin
        logic acc;
        logic nv;
        exp_t e;
        exp_t n;
        acc = in_valid && in_ready;
        checkOutput("out_valid", out_valid, exp_valid);
        checkOutput("frame_done", frame_done, exp_fd);
        checkOutput("in_ready", in_ready, !exp_valid || out_ready);
        if (frame_done) begin
            fd_cnt++;
            fd_win = out_window;
        end
        if (out_valid && !out_ready) stall_seen++;
        if (out_valid) begin
            checkOutput("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb[0];
                checkOutput("window", out_window, e.win);
                checkOutput("out_row", out_row, e.row);
                checkOutput("out_col", out_col, e.col);
                if (out_ready) begin
                    if (e.row == 7'd1 && e.col == 7'd1) first_win = out_window;
                    void'(sb.pop_front());
                    win_cnt++;
                end
            end
        end
        if (rst) begin
            sb.delete();
            mr = 0;
            mc = 0;
            exp_valid = 1'b0;
            exp_fd = 1'b0;
        end else begin
            nv = exp_valid && !out_ready;
            exp_fd = 1'b0;
            if (acc) begin
                frame[mr][mc] = in_pixel;
                nv = (mr >= 2 && mc >= 2);
                if (nv) begin
                    n.win = '0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            n.win[(r*3+c)*8 +: 8] = frame[mr-2+r][mc-2+c];
                    n.row = 7'(mr - 1);
                    n.col = 7'(mc - 1);
                    sb.push_back(n);
                end
                exp_fd = (mr == IMG_H-1 && mc == IMG_W-1);
                if (mc == IMG_W-1) begin
                    mc = 0;
                    mr = (mr == IMG_H-1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
            exp_valid = nv;
        end
    end

    // Offer one pixel, optionally after a random idle gap, and wait until it is taken.
    task automatic applyStimulus(input logic [7:0] px, input bit gaps);
        bit done = 1'b0;
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = px;
        while (!done && n < 200) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", done, 1'b1);
    endtask

    task automatic sendFrame(input int base, input bit gaps, input bit randpix);
        for (int i = 0; i < IMG_W*IMG_H; i++)
            applyStimulus(randpix ? 8'($urandom) : 8'(base + i), gaps);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || out_valid) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain", (sb.size() == 0) && !out_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_pixel = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int w0;
        int f0;
        int s0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_frame_done", frame_done, 1'b0);
        checkOutput("rst_window", out_window, 72'd0);
        checkOutput("rst_row", out_row, 7'd0);
        checkOutput("rst_col", out_col, 7'd0);
        @(posedge clk);
        #1;

        $display("[TB] ramp frame");
        w0 = win_cnt; f0 = fd_cnt; s0 = stall_seen;
        sendFrame(0, 1'b0, 1'b0);
        drain();
        checkOutput("ramp_windows", win_cnt - w0, 4);
        checkOutput("ramp_fd", fd_cnt - f0, 1);
        checkOutput("ramp_first", first_win, RAMP_FIRST);
        checkOutput("ramp_fd_window", fd_win, RAMP_LAST);
        checkOutput("ramp_nostall", stall_seen - s0, 0);

        $display("[TB] backpressure frame");
        w0 = win_cnt; f0 = fd_cnt; s0 = stall_seen;
        stall_arm = 1'b1;
        sendFrame(0, 1'b0, 1'b0);
        drain();
        checkOutput("bp_stall", stall_seen - s0, 5);
        checkOutput("bp_windows", win_cnt - w0, 4);
        checkOutput("bp_fd", fd_cnt - f0, 1);
        checkOutput("bp_first", first_win, RAMP_FIRST);
        checkOutput("bp_fd_window", fd_win, RAMP_LAST);

        $display("[TB] back-to-back frames");
        w0 = win_cnt; f0 = fd_cnt;
        sendFrame(0, 1'b0, 1'b0);
        sendFrame(100, 1'b0, 1'b0);
        drain();
        checkOutput("b2b_windows", win_cnt - w0, 8);
        checkOutput("b2b_fd", fd_cnt - f0, 2);
        checkOutput("b2b_first", first_win, F2_FIRST);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 7; i++) applyStimulus(8'(50 + i), 1'b0);
        pulseReset();
        w0 = win_cnt; f0 = fd_cnt;
        sendFrame(0, 1'b0, 1'b0);
        drain();
        checkOutput("rstmid_windows", win_cnt - w0, 4);
        checkOutput("rstmid_fd", fd_cnt - f0, 1);
        checkOutput("rstmid_first", first_win, RAMP_FIRST);
        checkOutput("rstmid_fd_window", fd_win, RAMP_LAST);

        $display("[TB] random gaps and ready");
        w0 = win_cnt; f0 = fd_cnt;
        rdy_random = 1'b1;
        repeat (3) sendFrame(0, 1'b1, 1'b1);
        drain();
        rdy_random = 1'b0;
        checkOutput("rand_windows", win_cnt - w0, 12);
        checkOutput("rand_fd", fd_cnt - f0, 3);
        checkOutput("sb_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so a stuck DUT can never hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
